serial_fir_mac: RTL and testbench

Time-multiplexed FIR filter with a single multiply-accumulate unit. It computes y[n] = sum over i of c[i]*x[n-i] across NTAP taps, the same transfer function as the team's parallel direct-form filter, using one multiplier over NTAP cycles per sample. It is the low-area counterpart for sample streams well below clock rate. Samples enter and results leave through valid/ready handshakes, and coefficients load through a register write port instead of static inputs.

---
 rtl/serial_fir_mac_if.sv | 28 ++
 rtl/serial_fir_mac.sv | 116 +++++++++++
 tb/tb_serial_fir_mac.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_fir_mac_if.sv
// Handshake and coefficient-port bundle for serial_fir_mac.
// The master drives samples and coefficient writes; the slave is the filter.
interface serial_fir_mac_if #(
  parameter int DW = 16,
  parameter int CW = 14,
  parameter int OW = 26
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic          coef_we;
  logic [3:0]    coef_addr;
  logic [CW-1:0] coef_wdata;
  logic          coef_err;

  modport master (
    output in_valid, in_data, out_ready, coef_we, coef_addr, coef_wdata,
    input  in_ready, out_valid, out_data, coef_err
  );

  modport slave (
    input  in_valid, in_data, out_ready, coef_we, coef_addr, coef_wdata,
    output in_ready, out_valid, out_data, coef_err
  );
endinterface

// File: rtl/serial_fir_mac.sv
// Time-multiplexed FIR: one signed MAC walks all NTAP taps per accepted sample.
// Define SERIAL_FIR_SAT_EN to clamp the output to the OW range instead of wrapping.
module serial_fir_mac #(
  parameter int NTAP = 6,
  parameter int DW   = 16,
  parameter int CW   = 14,
  parameter int OW   = 26
) (
  input  logic             clk,
  input  logic             reset,
  serial_fir_mac_if.slave  bus
);
  localparam int ACC_W = DW + CW + 4;
  localparam int PW    = DW + CW;
  localparam int IW    = (NTAP > 1) ? $clog2(NTAP) : 1;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    DONE
  } state_t;

  state_t                  r_state;
  logic signed [DW-1:0]    r_x [NTAP];
  logic signed [CW-1:0]    r_c [NTAP];
  logic signed [ACC_W-1:0] r_acc;
  logic [IW-1:0]           r_idx;
  logic [OW-1:0]           r_out_data;
  logic                    r_out_valid;
  logic                    r_coef_err;

  logic signed [PW-1:0]    w_xe;
  logic signed [PW-1:0]    w_ce;
  logic signed [PW-1:0]    w_prod;
  logic signed [ACC_W-1:0] w_sum;
  logic [OW-1:0]           w_fmt;
  logic                    w_coef_ok;
  logic                    w_last;

  assign w_xe   = PW'(r_x[r_idx]);
  assign w_ce   = PW'(r_c[r_idx]);
  assign w_prod = w_xe * w_ce;
  assign w_sum  = r_acc + ACC_W'(w_prod);
  assign w_last = (r_idx == IW'(NTAP - 1));

  // Writes only land while idle and inside the bank; anything else is flagged.
  assign w_coef_ok = (r_state == IDLE) && ({1'b0, bus.coef_addr} < 5'(NTAP));

`ifdef SERIAL_FIR_SAT_EN
  localparam logic [OW-1:0] OMAX = {1'b0, {(OW-1){1'b1}}};
  localparam logic [OW-1:0] OMIN = {1'b1, {(OW-1){1'b0}}};
  logic [ACC_W-OW:0] w_hi;
  logic              w_ovf;

  assign w_hi  = w_sum[ACC_W-1:OW-1];
  assign w_ovf = !((&w_hi) || (~|w_hi));
  assign w_fmt = w_ovf ? (w_sum[ACC_W-1] ? OMIN : OMAX) : w_sum[OW-1:0];
`else
  assign w_fmt = w_sum[OW-1:0];
`endif

  assign bus.in_ready  = (r_state == IDLE) && !reset;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.coef_err  = r_coef_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_idx       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_coef_err  <= 1'b0;
      for (int i = 0; i < NTAP; i++) begin
        r_x[i] <= '0;
        r_c[i] <= '0;
      end
    end else begin
      r_coef_err <= bus.coef_we && !w_coef_ok;
      if (bus.coef_we && w_coef_ok) begin
        r_c[bus.coef_addr[IW-1:0]] <= bus.coef_wdata;
      end

      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_x[0] <= bus.in_data;
            for (int i = 1; i < NTAP; i++) begin
              r_x[i] <= r_x[i-1];
            end
            r_acc   <= '0;
            r_idx   <= '0;
            r_state <= MAC;
          end
        end
        MAC: begin
          r_acc <= w_sum;
          r_idx <= r_idx + 1'b1;
          if (w_last) begin
            r_out_data  <= w_fmt;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_fir_mac.sv
// Randomized self-checking bench for serial_fir_mac against a sum-of-products model.
// Expected outputs honour SERIAL_FIR_SAT_EN the same way the design build does.
module tb_serial_fir_mac;
  localparam int NTAP = 6;
  localparam int DW   = 16;
  localparam int CW   = 14;
  localparam int OW   = 26;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  serial_fir_mac_if #(.DW(DW), .CW(CW), .OW(OW)) bus();

  serial_fir_mac #(.NTAP(NTAP), .DW(DW), .CW(CW), .OW(OW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  longint mx [NTAP];
  longint mc [NTAP];

  // Reference: y = sum c[i]*x[n-i] in exact arithmetic, then narrowed to OW.
  function automatic logic [OW-1:0] expect_out();
    longint s;
    s = 0;
    for (int i = 0; i < NTAP; i++) s += mx[i] * mc[i];
`ifdef SERIAL_FIR_SAT_EN
    if (s > ((longint'(1) << (OW-1)) - 1)) s = (longint'(1) << (OW-1)) - 1;
    else if (s < -(longint'(1) << (OW-1))) s = -(longint'(1) << (OW-1));
`endif
    return s[OW-1:0];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NTAP; i++) begin
      mx[i] = 0;
      mc[i] = 0;
    end
  endtask

  task automatic model_shift(input longint x);
    for (int i = NTAP-1; i > 0; i--) mx[i] = mx[i-1];
    mx[0] = x;
  endtask

  task automatic idle_inputs();
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.out_ready  = 1'b1;
    bus.coef_we    = 1'b0;
    bus.coef_addr  = '0;
    bus.coef_wdata = '0;
  endtask

  task automatic write_coef(input int addr, input longint val, output logic err);
    @(negedge clk);
    bus.coef_we    = 1'b1;
    bus.coef_addr  = addr[3:0];
    bus.coef_wdata = val[CW-1:0];
    @(negedge clk);
    bus.coef_we = 1'b0;
    err = bus.coef_err;
  endtask

  // Offers one sample, returns cycles from accept edge to out_valid and the result.
  task automatic push_sample(input longint x, output int lat, output logic [OW-1:0] y);
    int n;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = x[DW-1:0];
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    model_shift(x);
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    lat = n;
    y   = bus.out_data;
    if (bus.out_ready) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_in_ready: got %b expected 0", bus.in_ready);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid);
    end
    checks++;
    if (bus.out_data !== '0) begin
      errors++;
      $display("[TB] FAIL reset_out_data: got %0d expected 0", $signed(bus.out_data));
    end
    checks++;
    if (bus.coef_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_coef_err: got %b expected 0", bus.coef_err);
    end
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL post_reset_in_ready: got %b expected 1", bus.in_ready);
    end
  endtask

  task automatic test_impulse();
    logic err;
    int lat;
    logic [OW-1:0] y;
    longint v;
    for (int i = 0; i < NTAP; i++) begin
      write_coef(i, i + 1, err);
      mc[i] = i + 1;
      checks++;
      if (err !== 1'b0) begin
        errors++;
        $display("[TB] FAIL impulse_coef_err[%0d]: got %b expected 0", i, err);
      end
    end
    for (int s = 0; s < NTAP; s++) begin
      push_sample((s == 0) ? 1 : 0, lat, y);
      checks++;
      if (lat !== NTAP) begin
        errors++;
        $display("[TB] FAIL impulse_latency[%0d]: got %0d expected %0d", s, lat, NTAP);
      end
      v = s + 1;
      checks++;
      if (y !== expect_out() || y !== v[OW-1:0]) begin
        errors++;
        $display("[TB] FAIL impulse_out[%0d]: got %0d expected %0d", s, $signed(y), s + 1);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [OW-1:0] y, y2, exp1;
    longint x1, x2;
    x1 = longint'($urandom_range(0, 65535)) - 32768;
    x2 = longint'($urandom_range(0, 65535)) - 32768;
    bus.out_ready = 1'b0;
    push_sample(x1, lat, y);
    exp1 = expect_out();
    checks++;
    if (lat !== NTAP || y !== exp1) begin
      errors++;
      $display("[TB] FAIL bp_first: got lat=%0d y=%0d expected lat=%0d y=%0d",
               lat, $signed(y), NTAP, $signed(exp1));
    end
    bus.in_valid = 1'b1;
    bus.in_data  = x2[DW-1:0];
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if ({bus.out_valid, bus.in_ready, bus.out_data} !== {1'b1, 1'b0, exp1}) begin
        errors++;
        $display("[TB] FAIL bp_hold[%0d]: got valid=%b ready=%b data=%0d expected valid=1 ready=0 data=%0d",
                 c, bus.out_valid, bus.in_ready, $signed(bus.out_data), $signed(exp1));
      end
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL bp_release: got valid=%b ready=%b expected valid=0 ready=1",
               bus.out_valid, bus.in_ready);
    end
    push_sample(x2, lat, y2);
    checks++;
    if (y2 !== expect_out()) begin
      errors++;
      $display("[TB] FAIL bp_second: got %0d expected %0d", $signed(y2), $signed(expect_out()));
    end
  endtask

  task automatic test_overflow();
    logic err;
    int lat;
    int lit;
    logic [OW-1:0] y;
    for (int i = 0; i < NTAP; i++) begin
      write_coef(i, 8191, err);
      mc[i] = 8191;
    end
    for (int s = 0; s < NTAP; s++) begin
      push_sample(32767, lat, y);
      checks++;
      if (y !== expect_out()) begin
        errors++;
        $display("[TB] FAIL overflow_out[%0d]: got %0d expected %0d", s, $signed(y), $signed(expect_out()));
      end
    end
`ifdef SERIAL_FIR_SAT_EN
    lit = 33554431;
`else
    lit = -245754;
`endif
    checks++;
    if (y !== lit[OW-1:0]) begin
      errors++;
      $display("[TB] FAIL overflow_sixth: got %0d expected %0d", $signed(y), lit);
    end
  endtask

  task automatic test_coef_err();
    logic err;
    int lat, n;
    logic [OW-1:0] y;
    longint v;
    for (int i = 0; i < NTAP; i++) begin
      v = longint'($urandom_range(0, 16383)) - 8192;
      write_coef(i, v, err);
      mc[i] = v;
    end
    write_coef(6, 123, err);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL coef_err_addr6: got %b expected 1", err);
    end
    // Write while the MAC is running must be dropped.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'sd1234;
    @(negedge clk);
    bus.in_valid   = 1'b0;
    model_shift(1234);
    bus.coef_we    = 1'b1;
    bus.coef_addr  = 4'd0;
    bus.coef_wdata = 14'sd77;
    @(negedge clk);
    bus.coef_we = 1'b0;
    checks++;
    if (bus.coef_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL coef_err_mac: got %b expected 1", bus.coef_err);
    end
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== expect_out()) begin
      errors++;
      $display("[TB] FAIL coef_mac_unchanged: got %0d expected %0d", $signed(bus.out_data), $signed(expect_out()));
    end
    @(negedge clk);
    // Write coincident with accept must apply to this very sample.
    v = (mc[0] == 300) ? 301 : 300;
    bus.in_valid   = 1'b1;
    bus.in_data    = 16'sd1000;
    bus.coef_we    = 1'b1;
    bus.coef_addr  = 4'd0;
    bus.coef_wdata = v[CW-1:0];
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.coef_we  = 1'b0;
    mc[0] = v;
    model_shift(1000);
    checks++;
    if (bus.coef_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL coef_err_coincident: got %b expected 0", bus.coef_err);
    end
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== NTAP || bus.out_data !== expect_out()) begin
      errors++;
      $display("[TB] FAIL coef_coincident_out: got lat=%0d y=%0d expected lat=%0d y=%0d",
               n, $signed(bus.out_data), NTAP, $signed(expect_out()));
    end
    @(negedge clk);
    push_sample(-5, lat, y);
    checks++;
    if (y !== expect_out()) begin
      errors++;
      $display("[TB] FAIL coef_after_coincident: got %0d expected %0d", $signed(y), $signed(expect_out()));
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [OW-1:0] y;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'sd4321;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset_in_ready_low: got %b expected 0", bus.in_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({bus.out_valid, bus.in_ready, bus.coef_err} !== 3'b010 || bus.out_data !== '0) begin
      errors++;
      $display("[TB] FAIL mid_reset_state: got valid=%b ready=%b err=%b data=%0d expected 0 1 0 0",
               bus.out_valid, bus.in_ready, bus.coef_err, $signed(bus.out_data));
    end
    push_sample(100, lat, y);
    checks++;
    if (lat !== NTAP || y !== expect_out() || y !== '0) begin
      errors++;
      $display("[TB] FAIL mid_reset_sample: got lat=%0d y=%0d expected lat=%0d y=0", lat, $signed(y), NTAP);
    end
  endtask

  task automatic test_negative();
    logic err;
    int lat;
    logic [OW-1:0] y;
    int lit;
    write_coef(0, -8192, err);
    mc[0] = -8192;
    for (int i = 1; i < NTAP; i++) begin
      write_coef(i, 0, err);
      mc[i] = 0;
    end
    push_sample(-32768, lat, y);
`ifdef SERIAL_FIR_SAT_EN
    lit = 33554431;
`else
    lit = 0;
`endif
    checks++;
    if (y !== expect_out() || y !== lit[OW-1:0]) begin
      errors++;
      $display("[TB] FAIL negative_out: got %0d expected %0d", $signed(y), lit);
    end
  endtask

  task automatic test_random();
    logic err;
    int lat;
    logic [OW-1:0] y;
    longint v;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NTAP; i++) begin
        v = longint'($urandom_range(0, 16383)) - 8192;
        write_coef(i, v, err);
        mc[i] = v;
      end
      for (int s = 0; s < 8; s++) begin
        v = longint'($urandom_range(0, 65535)) - 32768;
        push_sample(v, lat, y);
        checks++;
        if (lat !== NTAP || y !== expect_out()) begin
          errors++;
          $display("[TB] FAIL random[%0d.%0d]: got lat=%0d y=%0d expected lat=%0d y=%0d",
                   r, s, lat, $signed(y), NTAP, $signed(expect_out()));
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_impulse();
    test_backpressure();
    test_overflow();
    test_coef_err();
    test_reset_mid();
    test_negative();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
